// File: rtl/fetch_ref_luma_loader.sv
// Luma reference window loader: fetches an 80x96 window per LCU row by row
// from the external port, replicates picture-edge pixels and writes full rows.
module fetch_ref_luma_loader #(
  parameter int PIXEL_WIDTH = 8,
  parameter int BUS_PIX     = 16,
  parameter int ROWS        = 80,
  parameter int WIN_W       = 96,
  parameter int MARGIN      = 16,
  parameter int XW          = 12,
  parameter int LW          = 6
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         start_i,
  input  logic [LW-1:0]                lcu_x_i,
  input  logic [LW-1:0]                lcu_y_i,
  input  logic [LW-1:0]                total_x_i,
  input  logic [LW-1:0]                total_y_i,
  output logic                         ext_req_o,
  input  logic                         ext_ack_i,
  output logic [XW-1:0]                ext_req_x_o,
  output logic [XW-1:0]                ext_req_y_o,
  output logic [2:0]                   ext_req_len_o,
  input  logic [BUS_PIX*PIXEL_WIDTH-1:0] ext_rdata_i,
  input  logic                         ext_rvalid_i,
  output logic                         load_valid_o,
  output logic [6:0]                   load_addr_o,
  output logic [WIN_W*PIXEL_WIDTH-1:0] load_data_o,
  output logic                         load_done_o,
  output logic                         busy_o,
  output logic [2:0]                   dbg_state_o,
  output logic                         dbg_bottom_o
);

  localparam int BUS_W     = BUS_PIX * PIXEL_WIDTH;
  localparam int ROW_W     = WIN_W * PIXEL_WIDTH;
  localparam int PW        = PIXEL_WIDTH;
  localparam int LCU_SHIFT = $clog2(WIN_W - 2 * MARGIN);

  localparam logic [2:0] LEN_FULL = 3'(WIN_W / BUS_PIX);
  localparam logic [2:0] LEN_EDGE = 3'((WIN_W - MARGIN) / BUS_PIX);
  localparam logic [2:0] LEN_BOTH = 3'((WIN_W - 2 * MARGIN) / BUS_PIX);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [LW-1:0]    lcu_x_q, lcu_x_d;
  logic [LW-1:0]    lcu_y_q, lcu_y_d;
  logic [LW-1:0]    total_x_q, total_x_d;
  logic [LW-1:0]    total_y_q, total_y_d;
  logic [6:0]       row_q, row_d;
  logic [2:0]       beat_cnt_q, beat_cnt_d;
  logic [ROW_W-1:0] row_sr_q, row_sr_d;
  logic             ext_req_q, ext_req_d;

  logic             left_edge, right_edge;
  logic [XW-1:0]    req_x, req_y, base_y;
  logic [2:0]       req_len, beat_nxt;
  logic [ROW_W-1:0] pad_data;

  assign left_edge  = (lcu_x_q == '0);
  assign right_edge = (lcu_x_q == total_x_q);
  assign req_x      = left_edge ? '0 : (XW'(lcu_x_q) << LCU_SHIFT) - XW'(MARGIN);
  assign base_y     = (lcu_y_q == '0) ? '0 : (XW'(lcu_y_q) << LCU_SHIFT) - XW'(MARGIN);
  assign req_y      = base_y + XW'(row_q);
  assign req_len    = (left_edge && right_edge) ? LEN_BOTH :
                      (left_edge || right_edge) ? LEN_EDGE : LEN_FULL;
  assign beat_nxt   = beat_cnt_q + 3'd1;

  // Fetched pixels sit right-aligned in row_sr_q; a right edge first moves
  // them up by MARGIN so interior columns line up with window columns.
  always_comb begin
    pad_data = row_sr_q;
    if (right_edge) begin
      pad_data = row_sr_q << (MARGIN * PW);
    end
    if (left_edge) begin
      for (int k = 0; k < MARGIN; k++) begin
        pad_data[(WIN_W-1-k)*PW +: PW] = right_edge ?
          row_sr_q[(WIN_W-1-2*MARGIN)*PW +: PW] : row_sr_q[(WIN_W-1-MARGIN)*PW +: PW];
      end
    end
    if (right_edge) begin
      for (int k = 0; k < MARGIN; k++) begin
        pad_data[k*PW +: PW] = row_sr_q[PW-1:0];
      end
    end
  end

  // ext_req_o is a valid held with x/y/len stable until the cycle ext_ack_i
  // is seen high; each ext_rvalid_i beat in DATA is consumed with no stall.
  always_comb begin
    state_d    = state_q;
    lcu_x_d    = lcu_x_q;
    lcu_y_d    = lcu_y_q;
    total_x_d  = total_x_q;
    total_y_d  = total_y_q;
    row_d      = row_q;
    beat_cnt_d = beat_cnt_q;
    row_sr_d   = row_sr_q;
    ext_req_d  = ext_req_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          lcu_x_d   = lcu_x_i;
          lcu_y_d   = lcu_y_i;
          total_x_d = total_x_i;
          total_y_d = total_y_i;
          row_d     = '0;
          ext_req_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (ext_ack_i) begin
          ext_req_d  = 1'b0;
          beat_cnt_d = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (ext_rvalid_i) begin
          row_sr_d   = {row_sr_q[ROW_W-BUS_W-1:0], ext_rdata_i};
          beat_cnt_d = beat_nxt;
          if (beat_nxt == req_len) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (row_q == 7'(ROWS - 1)) begin
          state_d = S_DONE;
        end else begin
          row_d     = row_q + 7'd1;
          ext_req_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      lcu_x_q    <= '0;
      lcu_y_q    <= '0;
      total_x_q  <= '0;
      total_y_q  <= '0;
      row_q      <= '0;
      beat_cnt_q <= '0;
      row_sr_q   <= '0;
      ext_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lcu_x_q    <= lcu_x_d;
      lcu_y_q    <= lcu_y_d;
      total_x_q  <= total_x_d;
      total_y_q  <= total_y_d;
      row_q      <= row_d;
      beat_cnt_q <= beat_cnt_d;
      row_sr_q   <= row_sr_d;
      ext_req_q  <= ext_req_d;
    end
  end

  assign ext_req_o     = ext_req_q;
  assign ext_req_x_o   = ext_req_q ? req_x : '0;
  assign ext_req_y_o   = ext_req_q ? req_y : '0;
  assign ext_req_len_o = ext_req_q ? req_len : '0;
  assign load_valid_o  = (state_q == S_WRITE);
  assign load_addr_o   = load_valid_o ? row_q : '0;
  assign load_data_o   = load_valid_o ? pad_data : '0;
  assign load_done_o   = (state_q == S_DONE);
  assign busy_o        = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;
  assign dbg_bottom_o  = busy_o && (lcu_y_q == total_y_q);

endmodule

// File: tb/tb_fetch_ref_luma_loader.sv
// Bench for fetch_ref_luma_loader: memory responder, window model built from
// clamped picture coordinates, per-row scoreboard and literal spot checks.
module tb_fetch_ref_luma_loader;

  localparam int ROW_W = 768;
  localparam int EW    = 775;

  logic          clk, rstn, start_i;
  logic [5:0]    lcu_x_i, lcu_y_i, total_x_i, total_y_i;
  logic          ext_req_o, ext_ack_i, ext_rvalid_i;
  logic [11:0]   ext_req_x_o, ext_req_y_o;
  logic [2:0]    ext_req_len_o;
  logic [127:0]  ext_rdata_i;
  logic          load_valid_o, load_done_o, busy_o, dbg_bottom_o;
  logic [6:0]    load_addr_o;
  logic [ROW_W-1:0] load_data_o;
  logic [2:0]    dbg_state_o;

  fetch_ref_luma_loader dut (
    .clk(clk), .rstn(rstn), .start_i(start_i),
    .lcu_x_i(lcu_x_i), .lcu_y_i(lcu_y_i), .total_x_i(total_x_i), .total_y_i(total_y_i),
    .ext_req_o(ext_req_o), .ext_ack_i(ext_ack_i), .ext_req_x_o(ext_req_x_o),
    .ext_req_y_o(ext_req_y_o), .ext_req_len_o(ext_req_len_o),
    .ext_rdata_i(ext_rdata_i), .ext_rvalid_i(ext_rvalid_i),
    .load_valid_o(load_valid_o), .load_addr_o(load_addr_o), .load_data_o(load_data_o),
    .load_done_o(load_done_o), .busy_o(busy_o),
    .dbg_state_o(dbg_state_o), .dbg_bottom_o(dbg_bottom_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [EW-1:0]    exp_q[$];
  logic [26:0]      exp_req_q[$];
  int errors = 0, checks = 0;
  int ymul = 0, ack_delay = 0, max_gap = 0;
  int rows_written = 0, done_cnt = 0, done_cyc = 0, last_valid_cyc = 0, start_cyc = 0;
  int req_cnt = 0;
  logic [26:0]      first_req, last_req;
  logic [ROW_W-1:0] last_row;
  logic             done_prev = 1'b0;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected at cycle %0d", name, cyc);
  endtask

  function automatic logic [7:0] pix_val(input int x, input int y);
    return 8'((x + ymul * y) & 255);
  endfunction

  function automatic logic [7:0] pix(input logic [ROW_W-1:0] row, input int k);
    return row[(95-k)*8 +: 8];
  endfunction

  function automatic logic [127:0] beat_data(input int x0, input int y);
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[(15-i)*8 +: 8] = pix_val(x0 + i, y);
    return d;
  endfunction

  // window = picture columns lcu_x*64-16 .. +95, clamped to the picture
  task automatic push_model(input int lx, input int ly, input int tx);
    int last_x, win_l, lo, hi, base_y, px;
    logic [ROW_W-1:0] row;
    last_x = (tx + 1) * 64 - 1;
    win_l  = lx * 64 - 16;
    lo     = (win_l < 0) ? 0 : win_l;
    hi     = (win_l + 95 > last_x) ? last_x : win_l + 95;
    base_y = (ly == 0) ? 0 : ly * 64 - 16;
    for (int r = 0; r < 80; r++) begin
      exp_req_q.push_back({12'(lo), 12'(base_y + r), 3'((hi - lo + 1) / 16)});
      for (int k = 0; k < 96; k++) begin
        px = win_l + k;
        if (px < 0) px = 0;
        if (px > last_x) px = last_x;
        row[(95-k)*8 +: 8] = pix_val(px, base_y + r);
      end
      exp_q.push_back({7'(r), row});
    end
  endtask

  // driver tasks
  task automatic start_load(input int lx, input int ly, input int tx, input int ty);
    repeat (2) @(negedge clk);
    push_model(lx, ly, tx);
    rows_written = 0;
    req_cnt      = 0;
    lcu_x_i = 6'(lx); lcu_y_i = 6'(ly); total_x_i = 6'(tx); total_y_i = 6'(ty);
    start_i = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_after_start", busy_o, 1'b1);
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0;
    bit got;
    d0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_now(name);
  endtask

  task automatic serve_one();
    logic [11:0] rx, ry;
    logic [2:0]  rl;
    logic [26:0] e;
    int gap;
    rx = ext_req_x_o; ry = ext_req_y_o; rl = ext_req_len_o;
    if (exp_req_q.size() == 0) fail_now("req_unexpected");
    else begin
      e = exp_req_q.pop_front();
      check("req_x", rx, e[26:15]);
      check("req_y", ry, e[14:3]);
      check("req_len", rl, e[2:0]);
    end
    if (req_cnt == 0) first_req = {rx, ry, rl};
    last_req = {rx, ry, rl};
    req_cnt++;
    for (int d = 0; d < ack_delay; d++) begin
      @(negedge clk);
      if (!rstn) return;
      check("req_hold", {ext_req_o, ext_req_x_o, ext_req_y_o, ext_req_len_o}, {1'b1, rx, ry, rl});
    end
    ext_ack_i = 1'b1;
    @(negedge clk);
    ext_ack_i = 1'b0;
    if (!rstn) return;
    for (int b = 0; b < int'(rl); b++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        if (!rstn) return;
      end
      ext_rdata_i  = beat_data(int'(rx) + 16 * b, int'(ry));
      ext_rvalid_i = 1'b1;
      @(negedge clk);
      ext_rvalid_i = 1'b0;
      if (!rstn) return;
    end
  endtask

  initial begin
    ext_ack_i = 1'b0; ext_rvalid_i = 1'b0; ext_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rstn && ext_req_o) serve_one();
      ext_ack_i = 1'b0;
      ext_rvalid_i = 1'b0;
    end
  end

  // compare process
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rstn) begin
      if (done_prev) check("busy_after_done", busy_o, 1'b0);
      if (load_valid_o) begin
        if (exp_q.size() == 0) fail_now("row_unexpected");
        else begin
          e = exp_q.pop_front();
          check("row_addr", load_addr_o, e[EW-1:ROW_W]);
          check("row_data", load_data_o, e[ROW_W-1:0]);
        end
        check("busy_in_write", busy_o, 1'b1);
        last_row       = load_data_o;
        last_valid_cyc = cyc;
        rows_written++;
      end
      if (load_done_o) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_rows", rows_written, 80);
        check("done_after_write", cyc - last_valid_cyc, 1);
      end
      done_prev = load_done_o;
    end else begin
      done_prev = 1'b0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // final report follows the directed sequence
  initial begin
    int d0;
    rstn = 1'b0; start_i = 1'b0;
    lcu_x_i = '0; lcu_y_i = '0; total_x_i = '0; total_y_i = '0;
    repeat (3) @(negedge clk);
    check("rst_req", ext_req_o, 1'b0);
    check("rst_req_x", ext_req_x_o, 12'd0);
    check("rst_req_len", ext_req_len_o, 3'd0);
    check("rst_valid", load_valid_o, 1'b0);
    check("rst_data", load_data_o, '0);
    check("rst_done", load_done_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_state", dbg_state_o, 3'd0);
    check("rst_bottom", dbg_bottom_o, 1'b0);
    rstn = 1'b1;

    // interior LCU, zero wait
    ymul = 3; ack_delay = 0; max_gap = 0;
    start_load(2, 3, 5, 4);
    wait_done(1000, "t1_done_timeout");
    check("t1_latency", done_cyc - start_cyc + 1, 642);
    check("t1_first_req", first_req, {12'd112, 12'd176, 3'd6});
    check("t1_last_y", last_req[14:3], 12'd255);
    check("t1_req_count", req_cnt, 80);

    // left/top LCU, pixel value = x coordinate
    ymul = 0;
    start_load(0, 0, 5, 4);
    wait_done(1000, "t2_done_timeout");
    check("t2_first_req", first_req, {12'd0, 12'd0, 3'd5});
    check("t2_last_y", last_req[14:3], 12'd79);
    check("t2_pix0", pix(last_row, 0), 8'd0);
    check("t2_pix16", pix(last_row, 16), 8'd0);
    check("t2_pix17", pix(last_row, 17), 8'd1);
    check("t2_pix95", pix(last_row, 95), 8'd79);

    // right edge LCU
    start_load(5, 1, 5, 4);
    wait_done(1000, "t3_done_timeout");
    check("t3_first_req", first_req, {12'd304, 12'd48, 3'd5});
    check("t3_pix0", pix(last_row, 0), 8'd48);
    check("t3_pix79", pix(last_row, 79), 8'd127);
    check("t3_pix80", pix(last_row, 80), 8'd127);
    check("t3_pix95", pix(last_row, 95), 8'd127);

    // single-LCU-wide picture
    start_load(0, 0, 0, 0);
    wait_done(1000, "t4_done_timeout");
    check("t4_first_req", first_req, {12'd0, 12'd0, 3'd4});
    check("t4_pix15", pix(last_row, 15), 8'd0);
    check("t4_pix17", pix(last_row, 17), 8'd1);
    check("t4_pix79", pix(last_row, 79), 8'd63);
    check("t4_pix95", pix(last_row, 95), 8'd63);

    // backpressure with stray start pulses while busy
    ymul = 3; ack_delay = 3; max_gap = 2;
    d0 = done_cnt;
    start_load(2, 3, 5, 4);
    repeat (50) @(negedge clk);
    lcu_x_i = 6'd4; lcu_y_i = 6'd4; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (300) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(3000, "t5_done_timeout");
    repeat (5) @(negedge clk);
    check("t5_done_once", done_cnt - d0, 1);
    check("t5_rows_left", exp_q.size(), 0);
    check("t5_reqs_left", exp_req_q.size(), 0);

    // reset after row 40, then a clean reload
    ack_delay = 0; max_gap = 0;
    start_load(1, 1, 3, 3);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rows_written >= 41) break;
    end
    check("t6_rows_before_rst", rows_written, 41);
    @(negedge clk);
    d0 = done_cnt;
    rstn = 1'b0;
    #1;
    check("t6_rst_req", ext_req_o, 1'b0);
    check("t6_rst_valid", load_valid_o, 1'b0);
    check("t6_rst_addr", load_addr_o, 7'd0);
    check("t6_rst_busy", busy_o, 1'b0);
    check("t6_rst_done", load_done_o, 1'b0);
    @(negedge clk);
    exp_q.delete();
    exp_req_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    start_load(1, 1, 3, 3);
    wait_done(1000, "t6_done_timeout");
    check("t6_first_req", first_req, {12'd48, 12'd48, 3'd6});
    check("t6_rows_left", exp_q.size(), 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
